ahb_uart_tx: RTL

AHB-Lite slave UART transmitter that sits directly downstream of `m14k_sys` and consumes its HADDR/HWDATA/HWRITE bus traffic. Software writes bytes into a memory-mapped data register; they are buffered in a small FIFO and shifted out as 8N1 serial frames. It gives the MIPS system its first observable output in simulation and on the lab board.

---
 rtl/ahb_uart_pkg.sv | 32 +++
 rtl/uart_tx_fifo.sv | 59 +++++
 rtl/ahb_uart_tx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_uart_pkg.sv
// rtl/ahb_uart_pkg.sv - shared encodings, register map and FSM states for ahb_uart_tx
package ahb_uart_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Register offsets as seen on HADDR[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with same-cycle push/pop, even when full
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ahb_uart_tx.sv
// rtl/ahb_uart_tx.sv - AHB-Lite slave UART transmitter: bus registers, TX FIFO and 8N1 shifter
module ahb_uart_tx
  import ahb_uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        SI_ClkIn,
  input  logic        SI_ColdReset_N,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        uart_txd,
  output logic        tx_irq
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0]   BAUD_LOAD = BW'(CLK_DIV - 1);

  logic [1:0]      addr_q;
  logic            write_q;
  logic            valid_q;
  logic            htrans_active;
  logic            wr_en;
  logic            rd_en;
  logic [1:0]      ctrl_q;
  logic            ovf_q;

  logic            fifo_push;
  logic            fifo_pop;
  logic [7:0]      fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;

  tx_state_t       state_q, state_n;
  logic [BW-1:0]   baud_q, baud_n;
  logic [2:0]      idx_q, idx_n;
  logic [7:0]      shift_q, shift_n;
  logic            txd_n;
  logic            baud_done;
  logic            busy;

  logic            unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:8]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign htrans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

  always_ff @(posedge SI_ClkIn or negedge SI_ColdReset_N) begin
    if (!SI_ColdReset_N) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= HADDR[3:2];
      write_q <= HWRITE;
      valid_q <= HSEL & htrans_active & HREADY;
    end
  end

  assign wr_en     = valid_q & write_q;
  assign rd_en     = valid_q & ~write_q;
  assign fifo_push = wr_en && (addr_q == REG_DATA);

  always_ff @(posedge SI_ClkIn or negedge SI_ColdReset_N) begin
    if (!SI_ColdReset_N) begin
      ctrl_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en && (addr_q == REG_CTRL)) begin
        ctrl_q <= HWDATA[1:0];
      end
      if (fifo_push && fifo_full && !fifo_pop) begin
        ovf_q <= 1'b1;
      end else if (wr_en && (addr_q == REG_STATUS) && HWDATA[ST_OVF]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (SI_ClkIn),
    .rst_n (SI_ColdReset_N),
    .push  (fifo_push),
    .wdata (HWDATA[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy   = (state_q != IDLE);
  assign tx_irq = ctrl_q[CTRL_IRQ_EN] & fifo_empty & ~busy;

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (addr_q)
        REG_STATUS: begin
          HRDATA[ST_FULL]                 = fifo_full;
          HRDATA[ST_EMPTY]                = fifo_empty;
          HRDATA[ST_BUSY]                 = busy;
          HRDATA[ST_OVF]                  = ovf_q;
          HRDATA[ST_CNT_LSB +: ST_CNT_W]  = ST_CNT_W'(fifo_count);
        end
        REG_CTRL: HRDATA[1:0] = ctrl_q;
        default:  HRDATA = '0;
      endcase
    end
  end

  assign baud_done = (baud_q == '0);

  always_comb begin
    state_n  = state_q;
    baud_n   = baud_q;
    idx_n    = idx_q;
    shift_n  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_q[CTRL_EN] && !fifo_empty) begin
          state_n  = START;
          fifo_pop = 1'b1;
          shift_n  = fifo_rdata;
          baud_n   = BAUD_LOAD;
        end
      end
      START: begin
        if (baud_done) begin
          state_n = DATA;
          baud_n  = BAUD_LOAD;
          idx_n   = 3'd0;
        end else begin
          baud_n = baud_q - BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n  = BAUD_LOAD;
          shift_n = {1'b0, shift_q[7:1]};
          idx_n   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          baud_n = baud_q - BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          // Chain straight into the next start bit so queued bytes leave with no idle gap
          if (ctrl_q[CTRL_EN] && !fifo_empty) begin
            state_n  = START;
            fifo_pop = 1'b1;
            shift_n  = fifo_rdata;
            baud_n   = BAUD_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_q - BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The line level is derived from the next state so txd is a clean flop output
  always_comb begin
    txd_n = 1'b1;
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge SI_ClkIn or negedge SI_ColdReset_N) begin
    if (!SI_ColdReset_N) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      uart_txd <= 1'b1;
    end else begin
      state_q  <= state_n;
      baud_q   <= baud_n;
      idx_q    <= idx_n;
      shift_q  <= shift_n;
      uart_txd <= txd_n;
    end
  end

endmodule
